clock_rate_detector: RTL and testbench
======================================

# clock_rate_detector

Measures a divided clock produced from `clk_in` and reports which standard rate it is. Counts `clk_in` cycles between consecutive rising edges of the probed clock, checks the duty cycle, and classifies the period as the ÷32, ÷16 or ÷8 rate (clk_1 / clk_2 / clk_4). Raises `locked` after a stable run of matching periods. Flags loss of clock. Sits on the receive side of the clock distribution. It confirms that the lane logic is being fed the rate it expects.

## Interface
- `DIV_1`, 32: nominal period in `clk_in` cycles for the clk_1 rate.
- `DIV_2`, 16: nominal period for the clk_2 rate.
- `DIV_4`, 8: nominal period for the clk_4 rate.
- `TOL`, 0: allowed ± deviation in cycles for classification. Must be < DIV_4/2.
- `LOCK_CNT`, 4: consecutive matching periods required for lock (1..15).
- `TIMEOUT`, 64: cycles without a rising edge before loss of clock is declared. Must be > DIV_1.

- `clk_in`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clk_probe`  in  1  divided clock under test, sampled as data.
- `rate`  out  2  locked rate code: 00 none, 01 clk_1, 10 clk_2, 11 clk_4.
- `locked`  out  1  high while rate is stable.
- `period`  out  8  last measured period in cycles; saturates at 255.
- `duty_ok`  out  1  last measured high time equals `period/2` (integer division).
- `no_clk`  out  1  loss-of-clock flag.

## Operation
- Sampling: `s0` is `clk_probe` registered. `s1` is `s0` delayed by one cycle. A rising edge is `s0 & ~s1`.
- Period counter (8-bit, saturating at 255):
  - Loads 1 in the cycle after an edge.
  - Increments every cycle.
  - On the next edge, the captured value is the edge-to-edge distance. A ÷8 clock gives 8.
- High counter: counts cycles with `s0 = 1` since the last edge. It is captured at the same time as the period counter.
- Classification: the captured period `p` matches a rate when |p − DIV_x| ≤ TOL. Otherwise the class is 00.
- Match counter: 4-bit.
  - Increments when the class is non-zero and equals the previous class.
  - Is set to 1 when the class is non-zero but different from the previous class.
  - Is cleared when the class is 00.
- State machine:
  - IDLE: waiting for the first edge. No measurement is made. On an edge, go to MEASURE.
  - MEASURE: on each edge, capture and classify. When the match counter reaches LOCK_CNT, go to LOCKED and set `rate` to the class and `locked` to 1.
  - LOCKED: each edge re-classifies. On a mismatch or class 00, clear `locked`, set `rate` to 00, reload the match counter as above, and go to MEASURE.
  - Any state: if the period counter reaches TIMEOUT, set `no_clk` = 1, `locked` = 0, `rate` = 00, clear the match counter, and go to IDLE.
- `no_clk` clears on the next detected edge.
- The first edge after IDLE only starts counting. No period is reported for it.

## Timing
- Reset values: `rate` = 00, `locked` = 0, `period` = 0, `duty_ok` = 0, `no_clk` = 0. State is IDLE and all counters are 0.
- Latency: `clk_probe` rises at cycle n. The edge is detected at n+1. `period`, `duty_ok`, `rate` and `locked` update at n+2.
- Lock time: for a clean input, `locked` rises 2 cycles after the (LOCK_CNT+1)-th rising edge following reset or IDLE.
- Timeout: `no_clk` asserts in the cycle the counter equals TIMEOUT. An edge detected in that same cycle has priority, so there is no timeout.
- Reset in mid-operation returns all outputs to their reset values in the next cycle.
- A saturated `period` (255) always classifies as 00.

## Configuration
- `CLKDET_SYNC_EN`:
  - Defined: `clk_probe` passes through a 2-flop synchronizer before `s0`. This adds exactly 2 cycles to every latency above. Use it for probes from an unrelated domain.
  - Undefined: the probe is sampled directly with the latencies stated above.

## Test plan
- ÷8 probe (4 high / 4 low) after reset → `period` = 8, `duty_ok` = 1, `rate` = 11. `locked` = 1 two cycles after the 5th rising edge.
- ÷32 probe → `period` = 32, `rate` = 01, `locked` = 1. Repeat with ÷16 → `rate` = 10.
- Locked on ÷16, switch to ÷8 → `locked` = 0 and `rate` = 00 after the first 8-cycle period. Relock to 11 after 3 more matching periods.
- Hold `clk_probe` low after lock → `no_clk` = 1 at 64 cycles after the last edge, with `locked` = 0 and `rate` = 00. Restart toggling → `no_clk` clears on the first edge.
- Period 12 (6/6), and ÷16 with 10 high / 6 low → `rate` stays 00 for the first case. The second case gives `duty_ok` = 0 and `rate` still locks to 10.
- Assert `reset` while locked → all outputs at reset values on the next cycle. Relock takes the full lock time.

Source files
------------

// File: rtl/clock_rate_detector.sv
// clock_rate_detector: measures a divided probe clock and classifies its rate.
// Define CLKDET_SYNC_EN to put a 2-flop synchronizer in front of the edge detector.
module clock_rate_detector #(
   parameter int DIV_1    = 32,
   parameter int DIV_2    = 16,
   parameter int DIV_4    = 8,
   parameter int TOL      = 0,
   parameter int LOCK_CNT = 4,
   parameter int TIMEOUT  = 64
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       clk_probe,
   output logic [1:0] rate,
   output logic       locked,
   output logic [7:0] period,
   output logic       duty_ok,
   output logic       no_clk
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_e;

   localparam logic [7:0] TO_C  = 8'(TIMEOUT);
   localparam logic [3:0] LC_C  = 4'(LOCK_CNT);
   localparam logic [7:0] SAT_C = 8'hFF;

   state_e     state_q, state_d;
   logic       s0_q, s1_q;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] hi_q, hi_d;
   logic [3:0] mcnt_q, mcnt_d;
   logic [1:0] prev_q, prev_d;
   logic [1:0] rate_q, rate_d;
   logic       locked_q, locked_d;
   logic [7:0] period_q, period_d;
   logic       duty_q, duty_d;
   logic       nck_q, nck_d;

   logic       probe_w;
   logic       edge_w;
   logic       timeout_w;
   logic [1:0] cls_w;
   logic [3:0] mcnt_nx;

`ifdef CLKDET_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], clk_probe};
      end
   end

   assign probe_w = sync_q[1];
`else
   assign probe_w = clk_probe;
`endif

   function automatic logic near(
      input logic [7:0] p,
      input int         div
   );
      int d;
      d = int'(p) - div;
      return (p != SAT_C) && (d <= TOL) && (d >= -TOL);
   endfunction

   assign edge_w    = s0_q & ~s1_q;
   assign timeout_w = (cnt_q == TO_C) && !edge_w;

   always_comb begin
      cls_w = 2'b00;
      unique case (1'b1)
         near(cnt_q, DIV_1): cls_w = 2'b01;
         near(cnt_q, DIV_2): cls_w = 2'b10;
         near(cnt_q, DIV_4): cls_w = 2'b11;
         default:            cls_w = 2'b00;
      endcase
   end

   always_comb begin
      mcnt_nx = 4'd1;
      if (cls_w == 2'b00) begin
         mcnt_nx = 4'd0;
      end else if (cls_w == prev_q) begin
         mcnt_nx = (mcnt_q == 4'hF) ? mcnt_q : mcnt_q + 4'd1;
      end
   end

   // Period counter restarts at 1 so the edge-to-edge distance is captured directly.
   always_comb begin
      cnt_d = (cnt_q == SAT_C) ? cnt_q : cnt_q + 8'd1;
      hi_d  = hi_q;
      if (edge_w) begin
         cnt_d = 8'd1;
         hi_d  = 8'd1;
      end else if (s0_q && hi_q != SAT_C) begin
         hi_d = hi_q + 8'd1;
      end
   end

   always_comb begin
      state_d  = state_q;
      mcnt_d   = mcnt_q;
      prev_d   = prev_q;
      rate_d   = rate_q;
      locked_d = locked_q;
      period_d = period_q;
      duty_d   = duty_q;
      nck_d    = nck_q;
      if (edge_w) begin
         nck_d = 1'b0;
         unique case (state_q)
            IDLE: begin
               state_d = MEASURE;
            end
            MEASURE: begin
               period_d = cnt_q;
               duty_d   = (hi_q == {1'b0, cnt_q[7:1]});
               mcnt_d   = mcnt_nx;
               prev_d   = cls_w;
               if (mcnt_nx >= LC_C && cls_w != 2'b00) begin
                  state_d  = LOCKED;
                  rate_d   = cls_w;
                  locked_d = 1'b1;
               end
            end
            LOCKED: begin
               period_d = cnt_q;
               duty_d   = (hi_q == {1'b0, cnt_q[7:1]});
               mcnt_d   = mcnt_nx;
               prev_d   = cls_w;
               if (cls_w != rate_q) begin
                  state_d  = MEASURE;
                  rate_d   = 2'b00;
                  locked_d = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else if (timeout_w) begin
         state_d  = IDLE;
         nck_d    = 1'b1;
         locked_d = 1'b0;
         rate_d   = 2'b00;
         mcnt_d   = 4'd0;
         prev_d   = 2'b00;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q  <= IDLE;
         s0_q     <= 1'b0;
         s1_q     <= 1'b0;
         cnt_q    <= '0;
         hi_q     <= '0;
         mcnt_q   <= '0;
         prev_q   <= '0;
         rate_q   <= '0;
         locked_q <= 1'b0;
         period_q <= '0;
         duty_q   <= 1'b0;
         nck_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         s0_q     <= probe_w;
         s1_q     <= s0_q;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         mcnt_q   <= mcnt_d;
         prev_q   <= prev_d;
         rate_q   <= rate_d;
         locked_q <= locked_d;
         period_q <= period_d;
         duty_q   <= duty_d;
         nck_q    <= nck_d;
      end
   end

   assign rate    = rate_q;
   assign locked  = locked_q;
   assign period  = period_q;
   assign duty_ok = duty_q;
   assign no_clk  = nck_q;

endmodule

// File: tb/tb_clock_rate_detector.sv
// tb_clock_rate_detector: directed probe waveforms with a queued scoreboard.
// Expected outputs are checked a fixed latency after each probe rise.
module tb_clock_rate_detector;

`ifdef CLKDET_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic       clk_in = 1'b0;
   logic       reset;
   logic       clk_probe;
   logic [1:0] rate;
   logic       locked;
   logic [7:0] period;
   logic       duty_ok;
   logic       no_clk;

   clock_rate_detector dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .clk_probe (clk_probe),
      .rate      (rate),
      .locked    (locked),
      .period    (period),
      .duty_ok   (duty_ok),
      .no_clk    (no_clk)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int         hi;
      int         lo;
      bit         gap;
      bit         rst;
      logic [7:0] per;
      logic       duty;
      logic [1:0] rate;
      logic       lock;
   } row_t;

   row_t rows[$];
   row_t sb[$];
   int   due[$];
   int   to_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   nrise = 0;
   bit   pr_q  = 1'b0;
   bit   nck_p = 1'b0;
   bit   rst_s;

   // Expectations are the outputs seen right after this row's rising edge.
   function automatic void add(input int hi, input int lo, input bit g,
                               input bit r, input int per, input bit d,
                               input int rt, input bit lk);
      row_t x;
      x.hi = hi; x.lo = lo; x.gap = g; x.rst = r;
      x.per = 8'(per); x.duty = d; x.rate = 2'(rt); x.lock = lk;
      rows.push_back(x);
   endfunction

   initial begin
      add(4,4,0,0,  0,0,0,0);
      add(4,4,0,0,  8,1,0,0);
      add(4,4,0,0,  8,1,0,0);
      add(4,4,0,0,  8,1,0,0);
      add(4,4,0,0,  8,1,3,1);
      add(4,4,0,0,  8,1,3,1);
      add(16,16,0,0, 8,1,3,1);
      add(16,16,0,0,32,1,0,0);
      add(16,16,0,0,32,1,0,0);
      add(16,16,0,0,32,1,0,0);
      add(16,16,0,0,32,1,1,1);
      add(8,8,0,0,  32,1,1,1);
      add(8,8,0,0,  16,1,0,0);
      add(8,8,0,0,  16,1,0,0);
      add(8,8,0,0,  16,1,0,0);
      add(8,8,0,0,  16,1,2,1);
      add(4,4,0,0,  16,1,2,1);
      add(4,4,0,0,   8,1,0,0);
      add(4,4,0,0,   8,1,0,0);
      add(4,4,0,0,   8,1,0,0);
      add(4,4,0,0,   8,1,3,1);
      add(4,100,1,0, 8,1,3,1);
      add(4,4,0,0,   8,1,0,0);
      add(6,6,0,0,   8,1,0,0);
      add(6,6,0,0,  12,1,0,0);
      add(6,6,0,0,  12,1,0,0);
      add(6,6,0,0,  12,1,0,0);
      add(6,6,0,0,  12,1,0,0);
      add(10,6,0,0, 12,1,0,0);
      add(10,6,0,0, 16,0,0,0);
      add(10,6,0,0, 16,0,0,0);
      add(10,6,0,0, 16,0,0,0);
      add(10,6,0,0, 16,0,2,1);
      add(32,32,0,0,16,0,2,1);
      add(8,8,0,0,  64,1,0,0);
      add(8,8,0,0,  16,1,0,0);
      add(8,8,0,0,  16,1,0,0);
      add(8,8,0,0,  16,1,0,0);
      add(8,8,0,0,  16,1,2,1);
      add(8,8,0,1,   0,0,0,0);
      add(8,8,0,0,  16,1,0,0);
      add(8,8,0,0,  16,1,0,0);
      add(8,8,0,0,  16,1,0,0);
      add(8,8,0,0,  16,1,2,1);
      add(8,8,0,0,  16,1,2,1);

      reset     = 1'b1;
      clk_probe = 1'b0;
      repeat (3) @(negedge clk_in);
      reset = 1'b0;
      foreach (rows[i]) begin
         if (rows[i].rst) begin
            reset = 1'b1;
            repeat (2) @(negedge clk_in);
            reset = 1'b0;
         end
         sb.push_back(rows[i]);
         clk_probe = 1'b1;
         repeat (rows[i].hi) @(negedge clk_in);
         clk_probe = 1'b0;
         repeat (rows[i].lo) @(negedge clk_in);
      end
      repeat (10) @(negedge clk_in);
      total++;
      if (sb.size() != 0 || due.size() != 0) begin
         bad++;
         $display("FAIL leftover_rise got sb=%0d due=%0d want 0", sb.size(), due.size());
      end
      total++;
      if (to_q.size() != 0) begin
         bad++;
         $display("FAIL missing_no_clk got pending=%0d want 0", to_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      forever begin
         @(posedge clk_in);
         cyc++;
         rst_s = reset;
         if (clk_probe && !pr_q) due.push_back(cyc + LAT);
         pr_q = clk_probe;
         @(negedge clk_in);
         if (rst_s) begin
            total++;
            if ({rate, locked, period, duty_ok, no_clk} != 13'd0) begin
               bad++;
               $display("FAIL reset_out cyc=%0d got rate=%b lock=%b per=%0d duty=%b nck=%b want 0",
                        cyc, rate, locked, period, duty_ok, no_clk);
            end
         end
         if (due.size() != 0 && due[0] == cyc) begin
            void'(due.pop_front());
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL rise_unexpected cyc=%0d got rise want none", cyc);
            end else begin
               row_t e;
               e = sb.pop_front();
               if ({period, duty_ok, rate, locked, no_clk} !=
                   {e.per, e.duty, e.rate, e.lock, 1'b0}) begin
                  bad++;
                  $display("FAIL rise%0d got per=%0d duty=%b rate=%b lock=%b nck=%b want per=%0d duty=%b rate=%b lock=%b nck=0",
                           nrise, period, duty_ok, rate, locked, no_clk,
                           e.per, e.duty, e.rate, e.lock);
               end
               if (e.gap) to_q.push_back(cyc + 64);
            end
            nrise++;
         end
         if (no_clk && !nck_p) begin
            total++;
            if (to_q.size() == 0) begin
               bad++;
               $display("FAIL no_clk_unexpected cyc=%0d got 1 want 0", cyc);
            end else begin
               int w;
               w = to_q.pop_front();
               if (cyc != w || locked || rate != 2'b00) begin
                  bad++;
                  $display("FAIL no_clk_time got cyc=%0d lock=%b rate=%b want cyc=%0d lock=0 rate=00",
                           cyc, locked, rate, w);
               end
            end
         end
         nck_p = no_clk;
      end
   end

endmodule
